// File: rtl/led_seq_gen.sv
// Parametrised LED pattern sequencer: rotate, ping-pong, hold and fill patterns
// stepped by a programmable dwell prescaler.
module led_seq_gen #(
   parameter  int unsigned NLED  = 3,
   parameter  int unsigned CNT_W = 24,
   localparam int unsigned IDX_W = ($clog2(NLED) > 1) ? $clog2(NLED) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic [CNT_W-1:0] dwell,
   output logic [NLED-1:0]  light,
   output logic [IDX_W-1:0] idx,
   output logic             step_pulse
);

   localparam logic [1:0] M_ROT  = 2'b00;
   localparam logic [1:0] M_PING = 2'b01;
   localparam logic [1:0] M_HOLD = 2'b10;
   localparam logic [1:0] M_FILL = 2'b11;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NLED - 1);
   localparam logic [IDX_W-1:0] IDX_PREV = IDX_W'(NLED - 2);

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } pdir_t;

   pdir_t            pdir, pdir_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [IDX_W-1:0] idx_n;
   logic [1:0]       mode_q;
   logic [NLED-1:0]  light_n;
   logic             tick;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         pdir       <= UP;
         mode_q     <= M_ROT;
         light      <= NLED'(1);
         step_pulse <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         idx        <= idx_n;
         pdir       <= pdir_n;
         mode_q     <= mode;
         light      <= light_n;
         step_pulse <= tick;
      end
   end

   // Next state: prescaler, step index and ping-pong direction
   always_comb begin
      cnt_n  = cnt;
      idx_n  = idx;
      pdir_n = pdir;
      tick   = 1'b0;

      if (en) begin
         if (mode == M_HOLD) begin
            cnt_n = '0;
         end else if (cnt >= dwell) begin
            cnt_n = '0;
            tick  = 1'b1;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end

         if (mode != M_PING) begin
            pdir_n = pdir_t'(dir);
         end

         if (tick) begin
            if (mode == M_PING) begin
               if (pdir == UP) begin
                  if (idx == IDX_LAST) begin
                     pdir_n = DOWN;
                     idx_n  = IDX_PREV;
                  end else begin
                     idx_n  = idx + IDX_W'(1);
                  end
               end else begin
                  if (idx == '0) begin
                     pdir_n = UP;
                     idx_n  = IDX_W'(1);
                  end else begin
                     idx_n  = idx - IDX_W'(1);
                  end
               end
            end else if (!dir) begin
               idx_n = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
               idx_n = (idx == '0) ? IDX_LAST : idx - IDX_W'(1);
            end
         end
      end
   end

   // Output decode; light only needs refreshing when the index or mode moves
   always_comb begin
      light_n = light;
      if (tick || (mode != mode_q)) begin
         for (int unsigned i = 0; i < NLED; i++) begin
            light_n[i] = (mode == M_FILL) ? (IDX_W'(i) <= idx_n) : (IDX_W'(i) == idx_n);
         end
      end
   end

endmodule

// File: tb/tb_led_seq_gen.sv
// Scoreboard bench for led_seq_gen: two instances (3 and 4 lamps) share stimulus
// and are checked against a pattern-level reference model.
module tb_led_seq_gen;

   localparam int unsigned CNT_W = 24;
   localparam int unsigned NA    = 3;
   localparam int unsigned NB    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic             dir;
   logic [CNT_W-1:0] dwell;

   logic [NA-1:0] light_a;
   logic [1:0]    idx_a;
   logic          sp_a;
   logic [NB-1:0] light_b;
   logic [1:0]    idx_b;
   logic          sp_b;

   always #5 clk = ~clk;

   led_seq_gen #(.NLED(NA), .CNT_W(CNT_W)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .dwell(dwell),
      .light(light_a), .idx(idx_a), .step_pulse(sp_a)
   );

   led_seq_gen #(.NLED(NB), .CNT_W(CNT_W)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .dwell(dwell),
      .light(light_b), .idx(idx_b), .step_pulse(sp_b)
   );

   typedef struct {
      int cyc;
      int idx;
      int light;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int nl     [2] = '{NA, NB};
   int m_idx  [2] = '{0, 0};
   int m_cnt  [2] = '{0, 0};
   int m_down [2] = '{0, 0};
   int m_mode [2] = '{0, 0};
   int m_light[2] = '{1, 1};

   // Ping-pong as a walk around a cycle of 2(N-1) phases folded back onto the lamps
   function automatic void ping_step(input int n, inout int pos, inout int down);
      int period, ph;
      period = 2 * (n - 1);
      ph     = down ? (period - pos) % period : pos;
      ph     = (ph + 1) % period;
      pos    = (ph < n) ? ph : period - ph;
      down   = (ph >= n - 1) ? 1 : 0;
   endfunction

   // Reference model, evaluated at each rising edge
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         bit   step;
         exp_t e;
         step = 0;
         if (rst) begin
            m_cnt[k]  = 0;
            m_idx[k]  = 0;
            m_down[k] = 0;
            m_mode[k] = 0;
         end else begin
            if (en) begin
               if (mode == 2'b10) m_cnt[k] = 0;
               else if (m_cnt[k] >= int'(dwell)) begin
                  step     = 1;
                  m_cnt[k] = 0;
               end else m_cnt[k]++;
               if (step) begin
                  if (mode == 2'b01) ping_step(nl[k], m_idx[k], m_down[k]);
                  else if (!dir) m_idx[k] = (m_idx[k] + 1) % nl[k];
                  else m_idx[k] = (m_idx[k] + nl[k] - 1) % nl[k];
               end
               if (mode != 2'b01) m_down[k] = int'(dir);
            end
            m_mode[k] = int'(mode);
         end
         m_light[k] = (m_mode[k] == 3) ? (1 << (m_idx[k] + 1)) - 1 : (1 << m_idx[k]);
         if (step) begin
            e.cyc   = cyc;
            e.idx   = m_idx[k];
            e.light = m_light[k];
            if (k == 0) qa.push_back(e);
            else qb.push_back(e);
         end
      end
   end

   task automatic chk(input string name, input int k, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL dut%0d %s cycle %0d: got %0d expected %0d", k, name, cyc, act, exp_v);
      end
   endtask

   // Monitor: level checks every cycle, scoreboard pop on each step strobe
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int   a_idx, a_light;
         bit   a_sp, have;
         exp_t e;
         a_idx   = (k == 0) ? int'(idx_a) : int'(idx_b);
         a_light = (k == 0) ? int'(light_a) : int'(light_b);
         a_sp    = (k == 0) ? sp_a : sp_b;
         chk("idx", k, a_idx, m_idx[k]);
         chk("light", k, a_light, m_light[k]);
         have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
         if (have) e = (k == 0) ? qa[0] : qb[0];
         if (a_sp || (have && e.cyc <= cyc)) begin
            checks++;
            if (!have) begin
               errors++;
               $display("FAIL dut%0d step_pulse cycle %0d: got 1 expected 0", k, cyc);
            end else begin
               if (k == 0) void'(qa.pop_front());
               else void'(qb.pop_front());
               if (!a_sp || e.cyc != cyc || e.idx != a_idx || e.light != a_light) begin
                  errors++;
                  $display("FAIL dut%0d step cycle %0d: got sp=%0d idx=%0d light=%0d expected sp=1 at cycle %0d idx=%0d light=%0d",
                           k, cyc, a_sp, a_idx, a_light, e.cyc, e.idx, e.light);
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      cycles(n);
      rst = 1'b0;
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL wait %s: condition not reached, expected within bound", name);
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      mode  = 2'b00;
      dir   = 1'b0;
      dwell = '0;

      // Rotate, dwell 3
      en    = 1'b1;
      dwell = CNT_W'(3);
      do_reset(2);
      checks++;
      if (light_a !== 3'b001 || idx_a !== 2'd0 || sp_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got light=%b idx=%0d sp=%b expected light=001 idx=0 sp=0",
                  light_a, idx_a, sp_a);
      end
      cycles(20);

      // Ping-pong, dwell 0
      mode  = 2'b01;
      dwell = '0;
      do_reset(2);
      cycles(16);

      // Fill, decrementing, dwell 1
      mode  = 2'b11;
      dir   = 1'b1;
      dwell = CNT_W'(1);
      do_reset(2);
      cycles(16);

      // Enable and hold freeze
      mode  = 2'b00;
      dir   = 1'b0;
      dwell = CNT_W'(3);
      do_reset(1);
      for (int i = 0; i < 100 && m_idx[0] != 2; i++) cycles(1);
      if (m_idx[0] != 2) timeout_fail("idx2");
      en = 1'b0;
      cycles(10);
      en   = 1'b1;
      mode = 2'b10;
      cycles(10);
      mode = 2'b00;
      cycles(12);

      // Dwell shrink below the running count
      dwell = CNT_W'(100);
      for (int i = 0; i < 300 && m_cnt[0] != 50; i++) cycles(1);
      if (m_cnt[0] != 50) timeout_fail("cnt50");
      dwell = CNT_W'(5);
      cycles(20);

      // Mid-run reset while descending in ping-pong
      mode  = 2'b01;
      dwell = '0;
      for (int i = 0; i < 100 && !(m_down[1] == 1 && m_idx[1] == 2); i++) cycles(1);
      if (!(m_down[1] == 1 && m_idx[1] == 2)) timeout_fail("pingdown2");
      do_reset(1);
      cycles(10);

      // Randomised run
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) dir = ~dir;
         if ($urandom_range(0, 15) == 0) dwell = CNT_W'($urandom_range(0, 6));
         cycles(1);
      end
      rst = 1'b0;
      cycles(3);

      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_seq_gen.md
Name: led_seq_gen

Overview:
- Parametrised LED pattern sequencer; successor to the fixed 3-state, one-hot LED FSM.
- Drives NLED lamp outputs through a step index that advances on a programmable dwell prescaler.
- Modes: rotate, ping-pong, hold and fill (bar graph), with run-time direction and enable control.
- Sits between board-level lamp drivers and a simple control/register source.

Parameters:
- NLED, 3, number of LED outputs; legal range is ≥2.
- CNT_W, 24, width of the dwell prescaler and of the dwell input.
- IDX_W, derived as max(1,$clog2(NLED)), width of the step index (localparam, not overridable).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, run enable; when low, counting and stepping freeze.
- mode, input, 2, 00 rotate, 01 ping-pong, 10 hold, 11 fill.
- dir, input, 1, 0 means index increments, 1 means it decrements (rotate and fill modes).
- dwell, input, CNT_W, step period minus 1 in clk cycles.
- light, output, NLED, lamp pattern (registered).
- idx, output, IDX_W, current step index (registered).
- step_pulse, output, 1, one-cycle strobe asserted in the cycle the index changes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt=0, idx=0, pdir=up, mode_q=00.
  - light={{NLED-1{0}},1'b1}, step_pulse=0.
  - Reset wins over every other input and may be applied mid-step.
- Prescaler:
  - Applies when en=1 and mode≠hold.
  - If cnt>=dwell: tick; cnt<=0. Otherwise cnt<=cnt+1.
  - The >= comparison means lowering dwell below the current cnt causes a tick on the next edge.
  - dwell=0 gives one tick every cycle.
  - en=0: cnt, idx and pdir hold; step_pulse=0.
  - mode=hold: cnt<=0, no ticks, idx holds.
- Tick, rotate (00) and fill (11):
  - dir=0: idx<=(idx==NLED-1)?0:idx+1.
  - dir=1: idx<=(idx==0)?NLED-1:idx-1.
- Tick, ping-pong (01):
  - pdir=up: if idx==NLED-1 then pdir<=down and idx<=NLED-2; else idx<=idx+1.
  - pdir=down: if idx==0 then pdir<=up and idx<=1; else idx<=idx-1.
  - Ends are visited once per bounce, with no repeated step.
- pdir outside ping-pong: in any mode other than 01, pdir<=dir every cycle, so entering ping-pong starts in the dir direction.
- mode_q: registered copy of mode, sampled every cycle including when en=0.
- step_pulse: registered; equals 1 exactly in the cycle idx takes its new value.
- light:
  - Registered decode of next-state idx and mode; updates in the same cycle as idx.
  - Modes 00, 01, 10: one-hot, light[idx_next]=1.
  - Mode 11: thermometer, light[i]=1 for all i<=idx_next.
  - A mode change alters light on the next edge even without a tick; the index is unchanged.
- dir and dwell: sampled live, with no shadowing.
  - A dir change takes effect at the next tick.
  - A dwell change takes effect immediately via the comparison.
- Latency: light, idx and step_pulse all change on the same edge as the tick.
  - The first step after reset release, with en=1 and dwell=D, occurs D+1 cycles after the first enabled edge.
- Simultaneous events:
  - rst overrides en, mode and tick.
  - A mode change coincident with a tick: the tick uses the new mode's stepping rule (mode input), and light uses the new mode's decode.
- No combinational path exists from any input to any output.

Test Plan:
- Reset/default: NLED=3, rst for 2 cycles, en=1, mode=00, dir=0, dwell=3 → light 001 after reset; step_pulse every 4th cycle; light sequence 010,100,001,010; idx 1,2,0,1.
- Ping-pong: NLED=4, dwell=0, mode=01, from reset → idx 1,2,3,2,1,0,1 on consecutive cycles; light one-hot matches.
- Fill plus dir: NLED=4, mode=11, dir=1, dwell=1 → idx 3,2,1,0,3 every 2 cycles; light 1111,0111,0011,0001,1111.
- Enable/hold freeze: run to idx=2, drop en for 10 cycles → no step_pulse, idx/light constant. Switch to mode=10 for 10 cycles → same freeze, cnt cleared. Resume mode=00, dwell=3 → next step exactly 4 cycles later.
- Dwell shrink: dwell=100, wait until cnt=50, set dwell=5 → step_pulse on the next edge, then every 6 cycles.
- Mid-run reset: assert rst for 1 cycle during ping-pong descending at idx=2 → next cycle idx=0, light=0…01, step_pulse=0; resume ascends (pdir reloaded).
